axi_engine_seq: RTL

Test/traffic sequencer sitting directly upstream of the AXI engine. It drives the engine's `start_wr`/`start_rd` command interface with a programmed series of single-operation writes, then reads the same addresses back. Every returned `read_data` is checked against a regenerated pattern. Error count, first failing address and elapsed cycles are reported for the HBM/DDR4 bring-up and bandwidth tests.

---
 rtl/axi_engine_seq.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/axi_engine_seq.sv
// axi_engine_seq: writes a seeded pattern over a strided address range through the AXI engine,
// reads it back and checks it. Define SEQ_TIMEOUT_EN to enable the per-operation watchdog.
module axi_engine_seq #(
    parameter int ADDR_WIDTH     = 33,
    parameter int DATA_WIDTH     = 256,
    parameter int CNT_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_start,
    input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
    input  logic [ADDR_WIDTH-1:0] cfg_stride,
    input  logic [CNT_WIDTH-1:0]  cfg_count,
    input  logic [31:0]           cfg_seed,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  err_cnt,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic [31:0]           cycle_cnt,
    output logic                  timeout,
    output logic                  start_wr,
    output logic                  start_rd,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic [ADDR_WIDTH-1:0] read_addr,
    output logic [DATA_WIDTH-1:0] write_data,
    input  logic                  end_wr,
    input  logic                  end_rd,
    input  logic [DATA_WIDTH-1:0] read_data
);
    localparam int LANES = DATA_WIDTH / 32;

    if (DATA_WIDTH % 32 != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("axi_engine_seq: DATA_WIDTH must be a multiple of 32 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_WR_ISSUE, S_WR_WAIT, S_RD_ISSUE, S_RD_WAIT, S_DONE
    } state_t;

    state_t                r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_base, r_stride, r_addr, r_first_err;
    logic [CNT_WIDTH-1:0]  r_count, r_idx, r_err_cnt, w_idx_inc;
    logic [31:0]           r_seed, r_cycle_cnt, w_idx_sh;
    logic [DATA_WIDTH-1:0] w_pat;
    logic                  w_last, w_wr_ack, w_rd_ack, w_mismatch, w_expire;

    assign w_idx_inc  = r_idx + CNT_WIDTH'(1);
    assign w_last     = (w_idx_inc == r_count);
    assign w_wr_ack   = (r_state == S_WR_WAIT) && end_wr;
    assign w_rd_ack   = (r_state == S_RD_WAIT) && end_rd;
    assign w_idx_sh   = 32'(r_idx) << 8;
    assign w_mismatch = (read_data != w_pat);

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        assign w_pat[j*32 +: 32] = r_seed ^ w_idx_sh ^ 32'(j);
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (cfg_start) w_next = (cfg_count == '0) ? S_DONE : S_WR_ISSUE;
            S_WR_ISSUE: w_next = S_WR_WAIT;
            S_WR_WAIT: begin
                if (w_wr_ack)      w_next = w_last ? S_RD_ISSUE : S_WR_ISSUE;
                else if (w_expire) w_next = S_DONE;
            end
            S_RD_ISSUE: w_next = S_RD_WAIT;
            S_RD_WAIT: begin
                if (w_rd_ack)      w_next = w_last ? S_DONE : S_RD_ISSUE;
                else if (w_expire) w_next = S_DONE;
            end
            S_DONE:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (r_state != S_IDLE);
        done     = (r_state == S_DONE);
        start_wr = (r_state == S_WR_ISSUE);
        start_rd = (r_state == S_RD_ISSUE);
    end

    // Address advances incrementally; ADDR_WIDTH-bit adds give the required modulo wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_base      <= '0;
            r_stride    <= '0;
            r_count     <= '0;
            r_seed      <= '0;
            r_idx       <= '0;
            r_addr      <= '0;
            r_err_cnt   <= '0;
            r_first_err <= '0;
            r_cycle_cnt <= '0;
        end else begin
            if (r_state == S_IDLE && cfg_start) begin
                r_base      <= cfg_base_addr;
                r_stride    <= cfg_stride;
                r_count     <= cfg_count;
                r_seed      <= cfg_seed;
                r_idx       <= '0;
                r_addr      <= cfg_base_addr;
                r_err_cnt   <= '0;
                r_first_err <= '0;
                r_cycle_cnt <= '0;
            end else if (r_state != S_IDLE) begin
                r_cycle_cnt <= r_cycle_cnt + 32'd1;
            end
            if (w_rd_ack && w_mismatch) begin
                if (r_err_cnt == '0) r_first_err <= r_addr;
                if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
            end
            if (w_wr_ack || w_rd_ack) begin
                if (w_last) begin
                    r_idx  <= '0;
                    r_addr <= r_base;
                end else begin
                    r_idx  <= w_idx_inc;
                    r_addr <= r_addr + r_stride;
                end
            end
        end
    end

`ifdef SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] r_wd;
    logic            r_timeout, w_waiting;

    assign w_waiting = (r_state == S_WR_WAIT) || (r_state == S_RD_WAIT);
    assign w_expire  = w_waiting && (r_wd == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wd      <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (r_state == S_IDLE && cfg_start)        r_timeout <= 1'b0;
            else if (w_expire && !w_wr_ack && !w_rd_ack) r_timeout <= 1'b1;
            if (start_wr || start_rd) r_wd <= '0;
            else if (w_waiting)       r_wd <= r_wd + 1'b1;
        end
    end
    assign timeout = r_timeout;
`else
    assign w_expire = 1'b0;
    assign timeout  = 1'b0;
`endif

    assign err_cnt        = r_err_cnt;
    assign first_err_addr = r_first_err;
    assign cycle_cnt      = r_cycle_cnt;
    assign write_addr     = r_addr;
    assign read_addr      = r_addr;
    assign write_data     = busy ? w_pat : '0;
endmodule
